dbus_mem_responder: RTL and testbench
=====================================

Name: dbus_mem_responder

Overview:
- Responder end of the data-bus protocol driven by the pipeline core's memory stage. Accepts one dbus request at a time and models configurable wait states.
- Services reads and byte-strobed writes from an internal 64-bit-word array.
- Asserts addr_ok/data_ok exactly once per accepted request.
- Used as the bench memory behind the core's dreq/dresp, and as the template for the cache-side responder.

Parameters:
- WORDS, 4096, number of 64-bit words in the backing array (power of two).
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from acceptance to the data_ok cycle; legal range 1..15.
- STALL_RAND, 0, when 1 add 0..3 extra wait cycles taken from the LFSR at acceptance.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- dreq  in  dbus_req_t (140)  valid(1), addr(64), size(3: 0=B,1=H,2=W,3=D), strobe(8), data(64)
- dresp  out  dbus_resp_t (66)  addr_ok(1), data_ok(1), data(64)
- oob_flag  out  1  sticky: an accepted request fell outside [BASE_ADDR, BASE_ADDR+8*WORDS)
- misalign_flag  out  1  sticky: an accepted request had addr not aligned to 2^size

Behaviour:
- Clock and reset: one clock domain on clk. reset is synchronous and active-high.
- Reset: state=IDLE, dresp all zero, both flags 0, wait counter 0, LFSR=8'hA5. Array contents are not cleared. Reset asserted mid-transaction abandons it: no write commits and no data_ok is issued.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - If dreq.valid, accept: capture addr, size, strobe, data.
  - Load cnt = LATENCY-1 + extra. extra = STALL_RAND ? lfsr[1:0] : 0.
  - Next state is RESP if cnt==0, else WAIT.
- WAIT:
  - Decrement cnt; go to RESP when cnt reaches 0.
  - If dreq.valid is sampled low in WAIT, abandon: return to IDLE, no write, no response.
- RESP (exactly one cycle):
  - dresp.addr_ok=1, dresp.data_ok=1.
  - dresp.data = array word at captured index, value before any write in this cycle.
  - Next state is always IDLE.
  - A request present in the following cycle is a new request, accepted there.
- Timing: request accepted in cycle t gives data_ok in cycle t+LATENCY+extra. Back-to-back: the next request is accepted at t+LATENCY+extra+1.
- dresp is driven only from state/registers (no combinational path from dreq). Outside RESP, dresp is all zero.
- Index: idx = (addr - BASE_ADDR) >> 3, using the low log2(WORDS) bits. addr[2:0] selects nothing; the full 64-bit word is returned and the core extracts lanes.
- Write: committed at the clock edge ending the RESP cycle. For each i with strobe[i]=1, byte i of the word = data[8i+7:8i]. strobe==0 is a pure read.
- Out-of-range access:
  - Read returns 0, write is ignored, handshake is still completed.
  - oob_flag set at acceptance, cleared only by reset.
- Misaligned access: serviced normally; misalign_flag set at acceptance, cleared only by reset.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle while not in reset, regardless of state.
- Request fields that change after acceptance are ignored; captured values are used.
- The array is inferred as a single synchronous-read memory: read registered on entry to RESP, write at end of RESP.

Test Plan:
- Write then read, LATENCY=2: valid at t with addr=0x8000_0010, strobe=FF, data=0x1122334455667788 -> data_ok only at t+2. Read of the same addr accepted at t+3 -> data_ok at t+5, data=0x1122334455667788.
- Partial strobe: after the above, write strobe=0x0F, data=0xAAAAAAAA_BBBBBBBB -> subsequent read returns 0x11223344_BBBBBBBB.
- Out of range: read addr 0x7FFF_FFF8 -> data_ok after LATENCY, data=0, oob_flag=1 and still 1 after 10 idle cycles. A write there leaves all in-range words unchanged.
- Abandon and reset: valid drops at t+1 with LATENCY=4 -> no data_ok, write not committed. Reset asserted in WAIT -> dresp=0 next cycle, state IDLE, target word unchanged.
- Misalign: size=2 at addr 0x8000_0002 -> serviced, misalign_flag=1, oob_flag unchanged.
- STALL_RAND=1, LATENCY=1, 200 back-to-back reads -> every accept-to-data_ok gap in 1..4. Exactly one data_ok per accepted request, never two consecutive data_ok cycles.

Source files
------------

// File: rtl/dbus_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbus_mem_responder : single-outstanding dbus memory responder with wait states
// Rev 1.0
// ---------------------------------------------------------------------------
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_mem_responder
  import dbus_pkg::*;
#(
  parameter int          WORDS      = 4096,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 2,
  parameter int          STALL_RAND = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       oob_flag,
  output logic       misalign_flag
);

  localparam int          IDX_W   = $clog2(WORDS);
  localparam logic [63:0] WORDS64 = 64'(WORDS);
  localparam logic [4:0]  LAT_M1  = 5'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [7:0]       lfsr;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_oob;
  logic [7:0]       cap_strobe;
  logic [63:0]      cap_data;
  logic [63:0]      rd_word;
  logic [63:0]      mem [WORDS];

  logic [63:0]      req_off;
  logic             req_oob;
  logic             req_mis;
  logic [4:0]       load_cnt;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             lfsr_fb;

  assign req_off  = (dreq.addr - BASE_ADDR) >> 3;
  assign req_oob  = (dreq.addr < BASE_ADDR) || (req_off >= WORDS64);
  assign load_cnt = LAT_M1 + ((STALL_RAND != 0) ? {3'b000, lfsr[1:0]} : 5'd0);
  assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    req_mis = 1'b0;
    case (dreq.size)
      3'd0:    req_mis = 1'b0;
      3'd1:    req_mis = dreq.addr[0];
      3'd2:    req_mis = |dreq.addr[1:0];
      default: req_mis = |dreq.addr[2:0];
    endcase
  end

  // The array read is issued on the cycle that transitions into RESP.
  assign rd_en  = ((state == IDLE) && dreq.valid && (load_cnt == 5'd0)) ||
                  ((state == WAIT) && dreq.valid && (cnt == 5'd1));
  assign rd_idx = (state == IDLE) ? req_off[IDX_W-1:0] : cap_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 5'd0;
      lfsr          <= 8'hA5;
      oob_flag      <= 1'b0;
      misalign_flag <= 1'b0;
      cap_idx       <= '0;
      cap_oob       <= 1'b0;
      cap_strobe    <= 8'h00;
      cap_data      <= 64'h0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      case (state)
        IDLE: begin
          if (dreq.valid) begin
            cap_idx       <= req_off[IDX_W-1:0];
            cap_oob       <= req_oob;
            cap_strobe    <= dreq.strobe;
            cap_data      <= dreq.data;
            oob_flag      <= oob_flag | req_oob;
            misalign_flag <= misalign_flag | req_mis;
            cnt           <= load_cnt;
            state         <= (load_cnt == 5'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!dreq.valid) begin
            state <= IDLE;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write lands at the edge closing RESP, so the response carries the old word.
  always_ff @(posedge clk) begin
    if (rd_en) rd_word <= mem[rd_idx];
    if ((state == RESP) && !reset && !cap_oob) begin
      for (int i = 0; i < 8; i++) begin
        if (cap_strobe[i]) mem[cap_idx][8*i +: 8] <= cap_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    dresp = '0;
    if (state == RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = cap_oob ? 64'h0 : rd_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_mem_responder.sv
`default_nettype none
// Directed bench for dbus_mem_responder: three instances (LATENCY 2, LATENCY 4,
// LATENCY 1 with random stall) driven from one clock and reset.
module tb_dbus_mem_responder;
  import dbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  req  [3];
  dbus_resp_t resp [3];
  logic       oob  [3];
  logic       mis  [3];

  int tests = 0;
  int fails = 0;

  logic [7:0] lfsr_m;
  int         ok_cnt2  = 0;
  int         dbl2     = 0;
  logic       prev_ok2 = 1'b0;

  always #5 clk = ~clk;

  dbus_mem_responder #(.LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .dreq(req[0]), .dresp(resp[0]),
    .oob_flag(oob[0]), .misalign_flag(mis[0]));

  dbus_mem_responder #(.LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset), .dreq(req[1]), .dresp(resp[1]),
    .oob_flag(oob[1]), .misalign_flag(mis[1]));

  dbus_mem_responder #(.LATENCY(1), .STALL_RAND(1)) u_dutr (
    .clk(clk), .reset(reset), .dreq(req[2]), .dresp(resp[2]),
    .oob_flag(oob[2]), .misalign_flag(mis[2]));

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps every non-reset edge.
  always @(posedge clk)
    lfsr_m <= reset ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

  always @(negedge clk) begin
    if (reset) begin
      prev_ok2 = 1'b0;
    end else begin
      if (resp[2].data_ok) begin
        ok_cnt2++;
        if (prev_ok2) dbl2++;
      end
      prev_ok2 = resp[2].data_ok;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full handshake; valid held until data_ok, data field scrambled after accept.
  task automatic xact(input int d, input logic [63:0] a, input logic [2:0] sz,
                      input logic [7:0] st, input logic [63:0] wd,
                      output logic [63:0] rd, output int lat, output int ext);
    int stray = 0;
    @(posedge clk); #1;
    if (resp[d] != '0) stray++;
    req[d] = {1'b1, a, sz, st, wd};
    ext = int'(lfsr_m[1:0]);
    lat = -1;
    rd  = 64'h0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      req[d].data = ~wd;
      if (resp[d].data_ok) begin
        lat = k;
        rd  = resp[d].data;
        if (!resp[d].addr_ok) stray++;
        break;
      end else if (resp[d] != '0) begin
        stray++;
      end
    end
    req[d].valid = 1'b0;
    check("hs_quiet", 64'(stray), 64'd0);
  endtask

  task automatic wr(input int d, input string tag, input logic [63:0] a,
                    input logic [7:0] st, input logic [63:0] wd, input int explat,
                    output logic [63:0] old);
    int l, e;
    xact(d, a, 3'd3, st, wd, old, l, e);
    check(tag, 64'(l), 64'(explat));
  endtask

  task automatic rd_chk(input int d, input string tag, input logic [63:0] a,
                        input logic [2:0] sz, input logic [63:0] exp, input int explat);
    logic [63:0] r;
    int l, e;
    xact(d, a, sz, 8'h00, 64'h0, r, l, e);
    check({tag, "_lat"}, 64'(l), 64'(explat));
    check(tag, r, exp);
  endtask

  // Start a write, then kill it in WAIT by dropping valid or pulsing reset.
  task automatic interrupt(input int d, input logic [63:0] a, input logic [63:0] wd,
                           input bit use_reset, output int n_ok);
    n_ok = 0;
    @(posedge clk); #1;
    req[d] = {1'b1, a, 3'd3, 8'hFF, wd};
    @(posedge clk); #1;
    if (use_reset) reset = 1'b1;
    else req[d].valid = 1'b0;
    @(posedge clk); #1;
    if (resp[d].data_ok) n_ok++;
    if (use_reset) begin
      check("rst_resp_ok", {62'b0, resp[d].addr_ok, resp[d].data_ok}, 64'd0);
      check("rst_resp_data", resp[d].data, 64'h0);
      reset = 1'b0;
      req[d].valid = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (resp[d].data_ok) n_ok++;
    end
  endtask

  localparam logic [63:0] C0 = 64'h0F0E_0D0C_0B0A_0908;
  localparam logic [63:0] C1 = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] C2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] C3 = 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    logic [63:0] old;
    logic [63:0] r;
    logic [63:0] a;
    int          n_ok, l, e;
    int          bad_gap   = 0;
    int          bad_model = 0;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) req[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_resp_ok", {62'b0, resp[0].addr_ok, resp[0].data_ok}, 64'd0);
    check("reset_resp_data", resp[0].data, 64'h0);
    check("reset_oob", 64'(oob[0]), 64'd0);
    check("reset_mis", 64'(mis[0]), 64'd0);

    // LATENCY=2: full write, read-back, partial strobe
    wr(0, "wr_full_lat", 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 2, old);
    rd_chk(0, "rd_full", 64'h8000_0010, 3'd3, 64'h1122_3344_5566_7788, 2);
    wr(0, "wr_part_lat", 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 2, old);
    check("wr_part_old", old, 64'h1122_3344_5566_7788);
    rd_chk(0, "rd_part", 64'h8000_0010, 3'd3, 64'h1122_3344_BBBB_BBBB, 2);

    // First and last in-range words
    wr(0, "wr_w0_lat", 64'h8000_0000, 8'hFF, C0, 2, old);
    wr(0, "wr_wlast_lat", 64'h8000_7FF8, 8'hFF, C1, 2, old);
    rd_chk(0, "rd_wlast", 64'h8000_7FF8, 3'd3, C1, 2);
    check("inrange_oob", 64'(oob[0]), 64'd0);
    check("aligned_mis", 64'(mis[0]), 64'd0);

    // Misaligned word access at 0x8000_0002 returns word 0
    rd_chk(0, "rd_misal", 64'h8000_0002, 3'd2, C0, 2);
    check("misal_flag", 64'(mis[0]), 64'd1);
    check("misal_oob", 64'(oob[0]), 64'd0);

    // Out of range below base, then sticky check
    rd_chk(0, "rd_oob", 64'h7FFF_FFF8, 3'd3, 64'h0, 2);
    check("oob_flag", 64'(oob[0]), 64'd1);
    repeat (10) @(posedge clk);
    #1 check("oob_sticky", 64'(oob[0]), 64'd1);

    // Out-of-range writes (one aliases index 0, one aliases the last index)
    wr(0, "wr_oob_hi_lat", 64'h8000_8000, 8'hFF, C3, 2, old);
    check("wr_oob_hi_data", old, 64'h0);
    wr(0, "wr_oob_lo_lat", 64'h7FFF_FFF8, 8'hFF, C3, 2, old);
    rd_chk(0, "oob_keep_w0", 64'h8000_0000, 3'd3, C0, 2);
    rd_chk(0, "oob_keep_wlast", 64'h8000_7FF8, 3'd3, C1, 2);
    rd_chk(0, "oob_keep_w2", 64'h8000_0010, 3'd3, 64'h1122_3344_BBBB_BBBB, 2);

    // LATENCY=4: abandon and reset mid-transaction
    wr(1, "l4_wr_lat", 64'h8000_0020, 8'hFF, C2, 4, old);
    interrupt(1, 64'h8000_0020, C3, 1'b0, n_ok);
    check("abandon_no_ok", 64'(n_ok), 64'd0);
    rd_chk(1, "abandon_keep", 64'h8000_0020, 3'd3, C2, 4);
    interrupt(1, 64'h8000_0020, C3, 1'b1, n_ok);
    check("reset_no_ok", 64'(n_ok), 64'd0);
    check("reset_clr_oob", 64'(oob[0]), 64'd0);
    check("reset_clr_mis", 64'(mis[0]), 64'd0);
    rd_chk(1, "reset_keep", 64'h8000_0020, 3'd3, C2, 4);
    rd_chk(0, "reset_keep_mem", 64'h8000_0000, 3'd3, C0, 2);

    // LATENCY=1 with random stall: 200 back-to-back reads
    for (int i = 0; i < 200; i++) begin
      a = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 64'd8;
      xact(2, a, 3'd3, 8'h00, 64'h0, r, l, e);
      if (l < 1 || l > 4) bad_gap++;
      if (l != 1 + e) bad_model++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rand_gap_range", 64'(bad_gap), 64'd0);
    check("rand_gap_lfsr", 64'(bad_model), 64'd0);
    check("rand_ok_count", 64'(ok_cnt2), 64'd200);
    check("rand_no_double", 64'(dbl2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
